// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable word width, runtime CPOL/CPHA,
// runtime SCLK divider and NUM_CS active-low chip selects.
// Optional macro SPI_LSB_FIRST_EN adds lsb_first_i (LSB-first TX and RX).
module spi_master_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CS     = 2,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned CS_SEL_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  start_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic [CS_SEL_W-1:0]   cs_sel_i,
`ifdef SPI_LSB_FIRST_EN
  input  logic                  lsb_first_i,
`endif
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  spi_done_tick_o,
  output logic                  ready_o,
  output logic                  sclk_o,
  input  logic                  miso_i,
  output logic                  mosi_o,
  output logic [NUM_CS-1:0]     cs_n_o
);

  localparam int unsigned EDGE_W    = $clog2(2 * DATA_WIDTH);
  localparam int unsigned LAST_EDGE = 2 * DATA_WIDTH - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_TRANSFER, ST_HOLD} state_t;

  state_t                state_q;
  logic [DIV_WIDTH-1:0]  half_cnt_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [EDGE_W-1:0]     edge_cnt_q;
  logic                  cpha_q;
  logic                  lsb_q;
  logic [DATA_WIDTH-1:0] tx_q;
  logic [DATA_WIDTH-1:0] rx_q;

  logic                  lsb_in_c;
  logic                  half_done_c;
  logic                  edge_fire_c;
  logic                  leading_c;
  logic                  final_c;
  logic                  sample_c;
  logic                  shift_c;
  logic                  tx_bit_c;
  logic [DATA_WIDTH-1:0] tx_shift_c;
  logic                  din_bit_c;
  logic [DATA_WIDTH-1:0] din_shift_c;
  logic [DATA_WIDTH-1:0] rx_next_c;
  logic [NUM_CS-1:0]     cs_dec_c;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in_c = lsb_first_i;
`else
  assign lsb_in_c = 1'b0;
`endif

  // SCLK edge scheduling: one edge at the start of each of the 2*DATA_WIDTH half-periods
  always_comb begin
    half_done_c = (half_cnt_q == div_q);
    edge_fire_c = half_done_c &&
                  ((state_q == ST_SETUP) ||
                   ((state_q == ST_TRANSFER) && (edge_cnt_q != EDGE_W'(LAST_EDGE))));
    leading_c   = (state_q == ST_SETUP) || edge_cnt_q[0];
    final_c     = (state_q == ST_TRANSFER) && (edge_cnt_q == EDGE_W'(LAST_EDGE - 1));
    sample_c    = edge_fire_c && (leading_c != cpha_q);
    shift_c     = edge_fire_c && (leading_c == cpha_q) && !final_c;
  end

  // Bit-order dependent shift/sample helpers and chip-select decode
  always_comb begin
    tx_bit_c    = lsb_q ? tx_q[0] : tx_q[DATA_WIDTH-1];
    tx_shift_c  = lsb_q ? (tx_q >> 1) : (tx_q << 1);
    din_bit_c   = lsb_in_c ? din_i[0] : din_i[DATA_WIDTH-1];
    din_shift_c = lsb_in_c ? (din_i >> 1) : (din_i << 1);
    rx_next_c   = lsb_q ? {miso_i, rx_q[DATA_WIDTH-1:1]}
                        : {rx_q[DATA_WIDTH-2:0], miso_i};
    cs_dec_c    = '1;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      cs_dec_c[i] = (cs_sel_i != CS_SEL_W'(i));
    end
  end

  // Control FSM with registered SPI pins and handshake outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      half_cnt_q      <= '0;
      div_q           <= '0;
      edge_cnt_q      <= '0;
      cpha_q          <= 1'b0;
      lsb_q           <= 1'b0;
      tx_q            <= '0;
      rx_q            <= '0;
      dout_o          <= '0;
      spi_done_tick_o <= 1'b0;
      ready_o         <= 1'b1;
      sclk_o          <= 1'b0;
      mosi_o          <= 1'b0;
      cs_n_o          <= '1;
    end else begin
      spi_done_tick_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          sclk_o  <= cpol_i;
          cs_n_o  <= '1;
          ready_o <= 1'b1;
          if (start_i) begin
            state_q    <= ST_SETUP;
            ready_o    <= 1'b0;
            cs_n_o     <= cs_dec_c;
            half_cnt_q <= '0;
            div_q      <= div_i;
            cpha_q     <= cpha_i;
            lsb_q      <= lsb_in_c;
            rx_q       <= '0;
            if (!cpha_i) begin
              mosi_o <= din_bit_c;
              tx_q   <= din_shift_c;
            end else begin
              tx_q   <= din_i;
            end
          end
        end
        ST_SETUP, ST_TRANSFER: begin
          half_cnt_q <= half_done_c ? '0 : half_cnt_q + DIV_WIDTH'(1);
          if (edge_fire_c) begin
            sclk_o <= ~sclk_o;
          end
          if (sample_c) begin
            rx_q <= rx_next_c;
          end
          if (shift_c) begin
            mosi_o <= tx_bit_c;
            tx_q   <= tx_shift_c;
          end
          if (half_done_c) begin
            if (state_q == ST_SETUP) begin
              state_q    <= ST_TRANSFER;
              edge_cnt_q <= '0;
            end else if (edge_cnt_q == EDGE_W'(LAST_EDGE)) begin
              state_q <= ST_HOLD;
            end else begin
              edge_cnt_q <= edge_cnt_q + EDGE_W'(1);
            end
          end
        end
        ST_HOLD: begin
          half_cnt_q <= half_done_c ? '0 : half_cnt_q + DIV_WIDTH'(1);
          if (half_done_c) begin
            state_q         <= ST_IDLE;
            spi_done_tick_o <= 1'b1;
            ready_o         <= 1'b1;
            dout_o          <= rx_q;
            cs_n_o          <= '1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: vector table, randomized transfers against an
// SPI-slave reference model, and hand sequences for back-to-back, reset and CS range.
module tb_spi_master_param;

  localparam int unsigned DW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        start;
  logic        cpol;
  logic        cpha;
  logic [15:0] div;
  logic [0:0]  sel;
  logic        loop_en;
  logic        slave_bit;
  logic        miso;
  logic [7:0]  dout;
  logic        done;
  logic        ready;
  logic        sclk;
  logic        mosi;
  logic [1:0]  cs_n;

  logic        start3;
  logic [1:0]  sel3;
  logic [7:0]  dout3;
  logic        done3;
  logic        ready3;
  logic        sclk3;
  logic        mosi3;
  logic [2:0]  cs3;
`ifdef SPI_LSB_FIRST_EN
  logic        lsb_first;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign miso = loop_en ? mosi : slave_bit;

  spi_master_param #(.DATA_WIDTH(DW), .NUM_CS(2), .DIV_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .din_i(din), .start_i(start), .cpol_i(cpol),
    .cpha_i(cpha), .div_i(div), .cs_sel_i(sel),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first_i(lsb_first),
`endif
    .dout_o(dout), .spi_done_tick_o(done), .ready_o(ready), .sclk_o(sclk),
    .miso_i(miso), .mosi_o(mosi), .cs_n_o(cs_n)
  );

  spi_master_param #(.DATA_WIDTH(DW), .NUM_CS(3), .DIV_WIDTH(16)) dut3 (
    .clk_i(clk), .rst_i(rst), .din_i(din), .start_i(start3), .cpol_i(cpol),
    .cpha_i(cpha), .div_i(div), .cs_sel_i(sel3),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first_i(lsb_first),
`endif
    .dout_o(dout3), .spi_done_tick_o(done3), .ready_o(ready3), .sclk_o(sclk3),
    .miso_i(mosi3), .mosi_o(mosi3), .cs_n_o(cs3)
  );

  typedef struct {
    logic [7:0]  din;
    logic        pol;
    logic        pha;
    logic [15:0] dv;
    logic        s;
    logic [7:0]  sw;
    logic        lp;
    logic [7:0]  exp_dout;
    logic [1:0]  exp_cs;
    int          exp_lat;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transfer on dut, with the bench acting as SPI slave (drives sw, captures mosi)
  task automatic run_xfer(input logic [7:0] d, input logic pol, input logic pha,
                          input logic [15:0] dv, input logic s, input logic [7:0] sw,
                          input logic lp, output logic [7:0] tx_cap, output int lat,
                          output int edges, output logic [1:0] cs_seen,
                          output logic first_mosi);
    int   drv;
    logic prev;
    logic lead;
    din = d; cpol = pol; cpha = pha; div = dv; sel = s; loop_en = lp; start = 1'b1;
    step();
    start      = 1'b0;
    cs_seen    = cs_n;
    first_mosi = mosi;
    prev       = sclk;
    drv        = 0;
    tx_cap     = '0;
    lat        = 0;
    edges      = 0;
    if (!pha) begin
      slave_bit = sw[7];
      drv = 1;
    end
    while (lat < 400) begin
      step();
      lat++;
      if (done) break;
      if (sclk !== prev) begin
        edges++;
        lead = (sclk !== pol);
        if (lead ^ pha) begin
          tx_cap = {tx_cap[6:0], mosi};
        end else if (drv < 8) begin
          slave_bit = sw[7 - drv];
          drv++;
        end
      end
      prev = sclk;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  tx_cap;
    logic [1:0]  cs_seen;
    logic        first_mosi;
    logic [7:0]  d, sw, held;
    logic [15:0] dv;
    logic        pol, pha, s, lp;
    int          lat, edges, cyc;
    logic        bad;

    rst = 1'b1; din = '0; start = 1'b0; cpol = 1'b0; cpha = 1'b0; div = '0;
    sel = '0; loop_en = 1'b1; slave_bit = 1'b0; start3 = 1'b0; sel3 = '0;
`ifdef SPI_LSB_FIRST_EN
    lsb_first = 1'b0;
`endif

    tbl[0] = '{8'hA5, 1'b0, 1'b0, 16'd1, 1'b0, 8'h00, 1'b1, 8'hA5, 2'b10, 36};
    tbl[1] = '{8'h00, 1'b1, 1'b1, 16'd0, 1'b0, 8'h3C, 1'b0, 8'h3C, 2'b10, 18};
    tbl[2] = '{8'hFF, 1'b0, 1'b1, 16'd2, 1'b1, 8'h81, 1'b0, 8'h81, 2'b01, 54};
    tbl[3] = '{8'h5A, 1'b1, 1'b0, 16'd0, 1'b0, 8'h00, 1'b1, 8'h5A, 2'b10, 18};

    step(); step();
    check("rst_dout", dout, 0);
    check("rst_done", done, 0);
    check("rst_ready", ready, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_cs", cs_n, 2'b11);
    rst = 1'b0;
    step();

    // Vector table
    for (int i = 0; i < 4; i++) begin
      run_xfer(tbl[i].din, tbl[i].pol, tbl[i].pha, tbl[i].dv, tbl[i].s, tbl[i].sw,
               tbl[i].lp, tx_cap, lat, edges, cs_seen, first_mosi);
      check($sformatf("vec%0d_dout", i), dout, tbl[i].exp_dout);
      check($sformatf("vec%0d_cs", i), cs_seen, tbl[i].exp_cs);
      check($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
      check($sformatf("vec%0d_edges", i), edges, 2 * DW);
      check($sformatf("vec%0d_tx", i), tx_cap, tbl[i].din);
      check($sformatf("vec%0d_done_ready", i), ready, 1);
      check($sformatf("vec%0d_done_cs", i), cs_n, 2'b11);
      step();
      check($sformatf("vec%0d_tick_width", i), done, 0);
      check($sformatf("vec%0d_idle_sclk", i), sclk, tbl[i].pol);
      check($sformatf("vec%0d_dout_hold", i), dout, tbl[i].exp_dout);
    end

    // Randomized transfers against the slave reference model
    for (int i = 0; i < 24; i++) begin
      d   = 8'($urandom);
      sw  = 8'($urandom);
      pol = 1'($urandom);
      pha = 1'($urandom);
      s   = 1'($urandom);
      lp  = 1'($urandom);
      dv  = 16'($urandom_range(0, 3));
      run_xfer(d, pol, pha, dv, s, sw, lp, tx_cap, lat, edges, cs_seen, first_mosi);
      check($sformatf("rnd%0d_dout", i), dout, lp ? d : sw);
      check($sformatf("rnd%0d_tx", i), tx_cap, d);
      check($sformatf("rnd%0d_lat", i), lat, (2 * DW + 2) * (int'(dv) + 1));
      check($sformatf("rnd%0d_cs", i), cs_seen, s ? 2'b01 : 2'b10);
      check($sformatf("rnd%0d_edges", i), edges, 2 * DW);
      step();
    end

    // Back-to-back with start held high; mid-transfer din change has no effect
    din = 8'h11; cpol = 1'b0; cpha = 1'b0; div = '0; sel = '0; loop_en = 1'b1;
    start = 1'b1;
    step();
    lat = 0; bad = 1'b0;
    while (lat < 200) begin
      step();
      lat++;
      if (done) break;
      if (lat == 3) din = 8'h22;
      if (ready) bad = 1'b1;
    end
    check("b2b_first_lat", lat, 18);
    check("b2b_first_dout", dout, 8'h11);
    check("b2b_busy_ready", bad, 0);
    step();
    check("b2b_accept", ready, 0);
    check("b2b_tick_width", done, 0);
    lat = 0;
    while (lat < 200) begin
      step();
      lat++;
      if (done) break;
    end
    start = 1'b0;
    check("b2b_second_lat", lat, 18);
    check("b2b_second_dout", dout, 8'h22);
    step();
    check("b2b_idle", ready, 1);

    // Reset at the 5th SCLK edge
    din = 8'h5A; cpol = 1'b0; cpha = 1'b0; div = 16'd1; loop_en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    edges = 0; cyc = 0;
    while (edges < 5 && cyc < 200) begin
      logic p;
      p = sclk;
      step();
      cyc++;
      if (sclk !== p) edges++;
    end
    check("rst5_edges", edges, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst5_cs", cs_n, 2'b11);
    check("rst5_sclk", sclk, 0);
    check("rst5_ready", ready, 1);
    check("rst5_dout", dout, 0);
    check("rst5_done", done, 0);
    bad = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (done) bad = 1'b1;
    end
    check("rst5_no_tick", bad, 0);

    // Three chip selects: in-range and out-of-range select
    for (int k = 0; k < 2; k++) begin
      sel3 = (k == 0) ? 2'd3 : 2'd2;
      din = (k == 0) ? 8'hC3 : 8'h96;
      held = din;
      cpol = 1'b0; cpha = 1'b0; div = 16'd2; start3 = 1'b1;
      step();
      start3 = 1'b0;
      check($sformatf("cs3_sel%0d", sel3), cs3, (k == 0) ? 3'b111 : 3'b011);
      lat = 0;
      while (lat < 200) begin
        step();
        lat++;
        if (done3) break;
      end
      check($sformatf("cs3_sel%0d_lat", sel3), lat, 54);
      check($sformatf("cs3_sel%0d_dout", sel3), dout3, held);
      check($sformatf("cs3_sel%0d_ready", sel3), ready3, 1);
      check($sformatf("cs3_sel%0d_sclk", sel3), sclk3, 0);
      step();
    end

`ifdef SPI_LSB_FIRST_EN
    lsb_first = 1'b1;
    run_xfer(8'h01, 1'b0, 1'b0, 16'd1, 1'b0, 8'h00, 1'b1, tx_cap, lat, edges, cs_seen, first_mosi);
    check("lsb1_first_bit", first_mosi, 1);
    check("lsb1_dout", dout, 8'h01);
    check("lsb1_tx_reversed", tx_cap, 8'h80);
    step();
    lsb_first = 1'b0;
    run_xfer(8'h01, 1'b0, 1'b0, 16'd1, 1'b0, 8'h00, 1'b1, tx_cap, lat, edges, cs_seen, first_mosi);
    check("lsb0_first_bit", first_mosi, 0);
    check("lsb0_dout", dout, 8'h01);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
- Parametrised SPI master; next generation of the team's fixed 8-bit, single-mode SPI master.
- Adds configurable word width, runtime CPOL/CPHA mode, runtime SCLK divider and multiple chip selects.
- Sits between a register/streaming front end (din/start/dout handshake) and the SPI pins.
- Keeps the existing handshake signal set so the current SPI UVC extends with minimal change.

Parameters:
DATA_WIDTH, 8, bits per transfer (>=2)
NUM_CS, 2, number of active-low chip-select outputs (>=1)
DIV_WIDTH, 16, width of div_i
CS_SEL_W, (NUM_CS>1 ? $clog2(NUM_CS) : 1), width of cs_sel_i (derived, do not override)

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; one clock; synchronous, active-high
din_i  in  DATA_WIDTH  transmit word, sampled when start accepted
start_i  in  1  transfer request
cpol_i  in  1  SCLK idle level, sampled at start
cpha_i  in  1  0: sample leading edge; 1: sample trailing edge; sampled at start
div_i  in  DIV_WIDTH  half-period = div_i+1 clk cycles, sampled at start
cs_sel_i  in  CS_SEL_W  chip select index, sampled at start
dout_o  out  DATA_WIDTH  last received word
spi_done_tick_o  out  1  one-cycle pulse at transfer completion
ready_o  out  1  idle, start accepted
sclk_o  out  1  SPI clock
miso_i  in  1  serial input
mosi_o  out  1  serial output
cs_n_o  out  NUM_CS  active-low chip selects

Behaviour:
- All outputs registered. Reset values: dout_o=0, spi_done_tick_o=0, ready_o=1, sclk_o=0, mosi_o=0, cs_n_o=all 1s. State goes to IDLE.
- Let H = div_i+1, latched at start.
- FSM states:
  - IDLE: ready_o=1, sclk_o tracks cpol_i with one-cycle delay, cs_n_o all 1s. start_i=1 latches din/cpol/cpha/div/cs_sel and goes to SETUP.
  - SETUP: H cycles. Selected cs_n low, ready_o=0. If CPHA=0, mosi_o=first bit.
  - TRANSFER: 2*DATA_WIDTH half-periods of H cycles. sclk_o toggles at each half-period boundary, giving DATA_WIDTH full SCLK periods.
    - CPHA=0: sample miso on leading edge, shift mosi on trailing edge (no shift after the final edge).
    - CPHA=1: shift mosi on leading edge (first bit driven on first leading edge), sample on trailing edge.
  - HOLD: H cycles. sclk_o at CPOL, cs still asserted.
  - Then IDLE: cs_n_o all 1s, dout_o updated, spi_done_tick_o=1 for exactly this cycle, ready_o=1.
- Latency: done tick occurs (2*DATA_WIDTH+2)*H cycles after the first cycle with ready_o=0.
- Bit order is MSB first, both directions.
- start_i while ready_o=0: ignored.
- start_i in the done-tick cycle: accepted, giving back-to-back transfers with a single IDLE cycle between.
- din_i/mode/div/cs_sel changes mid-transfer have no effect.
- dout_o holds its value until the next completion.
- cs_sel_i >= NUM_CS: no cs asserted; transfer still runs with normal timing.
- div_i=0: H=1, SCLK = clk/2.
- rst_i mid-transfer: next cycle all outputs at reset values, FSM in IDLE, no done tick, dout_o=0.
- Shift and half-period counters sized from DATA_WIDTH/DIV_WIDTH. Counter wrap is never observable.

Optional Feature:
- Macro: SPI_LSB_FIRST_EN.
- Defined: adds input lsb_first_i (1 bit, sampled at start). When 1, both TX and RX are LSB first (received bits shift in from the MSB side, so dout_o is correctly ordered). When 0, MSB first.
- Undefined: port absent, MSB first only, behaviour identical to the above.

Test Plan:
1. DATA_WIDTH=8, cpol=0, cpha=0, div=1, din=0xA5, miso looped to mosi -> dout=0xA5. 8 sclk rising edges. Done tick 36 cycles after ready_o falls. cs_n_o=2'b10.
2. cpol=1, cpha=1, div=0, din=0x00, miso driven 0x3C (MSB first, changing on leading edge) -> dout=0x3C. sclk_o high in IDLE/SETUP/HOLD. mosi 0.
3. start held high continuously, din=0x11 then 0x22 -> second start accepted exactly in done-tick cycle. Starts during busy ignored. Two done ticks, dout 0x11 then 0x22 (loopback).
4. rst_i asserted at the 5th sclk edge of a transfer -> next cycle cs_n_o=11, sclk_o=0, ready_o=1, dout_o=0. No done tick.
5. cs_sel=1 -> cs_n_o=2'b01 during transfer. cs_sel out of range (NUM_CS=3, sel=3) -> cs_n_o=3'b111 and done tick still after (2*8+2)*H cycles.
6. SPI_LSB_FIRST_EN defined, lsb_first_i=1, din=0x01, loopback -> first mosi bit 1, dout=0x01. With lsb_first_i=0, first mosi bit 0.
